add_arbiter: RTL and testbench
==============================

# add_arbiter

Shares the single registered adder (`addr`: 1-bit operands `a`/`b`, 3-bit result `c`, one clock latency) among NREQ requesters. Arbitrates pending requests, drives the winning operands onto the adder, waits for the adder's latency, then returns the result tagged with the requester ID. Sits between the requester blocks and one `addr` instance. Only one operation is in flight at a time.

## Interface
- NREQ, 4, number of requesters (>= 2)
- W, 1, operand width per requester; the adder result width is CW = W+2
- ADD_LAT, 1, adder latency in clocks (>= 1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req  in  NREQ  requester i wants an add; held until its gnt bit is seen
- op_a  in  NREQ*W  operand a of requester i at [i*W +: W]
- op_b  in  NREQ*W  operand b of requester i at [i*W +: W]
- gnt  out  NREQ  one-hot, one-cycle pulse: the request was accepted and its operands captured
- add_a  out  W  to adder `a`
- add_b  out  W  to adder `b`
- add_c  in  CW  from adder `c`
- rsp_valid  out  1  one-cycle pulse: result available
- rsp_id  out  clog2(NREQ)  index of the requester owning the result
- rsp_data  out  CW  captured add_c
- busy  out  1  high while an operation is in flight

## Operation
- Two states: IDLE and WAIT. busy = (state == WAIT).
- IDLE, req != 0 at edge T:
  - Pick the winner and register its index.
  - Load add_a/add_b from the winner's operand slice.
  - Assert gnt[winner] during T+1.
  - Go to WAIT with the latency counter at 0.
- IDLE, req == 0: no change. add_a, add_b, rsp_id and rsp_data hold their last values.
- WAIT:
  - req is ignored, including a winner still holding req during its gnt cycle.
  - The counter increments every cycle.
  - At the edge where the counter equals ADD_LAT, capture add_c into rsp_data, load rsp_id with the stored winner, pulse rsp_valid for one cycle, and return to IDLE.
- A new arbitration may happen in the same cycle that rsp_valid is high, because the FSM is already in IDLE.
- A requester that keeps req high after its gnt competes again like any other requester.
- Operands are sampled only at the grant edge. Later changes on op_a/op_b do not affect the op in flight.
- rsp_data = add_c unmodified; no truncation or extension.
- Reset values: gnt=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state IDLE, priority pointer 0.
- Reset asserted mid-operation: abort immediately. The pending result is discarded and no rsp_valid is produced. Any later adder output is ignored.

## Timing
- Grant: request sampled at edge T; gnt and add_a/add_b are valid in cycle T+1.
- Adder: samples add_a/add_b at the end of T+1; add_c is valid from T+1+ADD_LAT.
- Response: rsp_valid is high in cycle T+2+ADD_LAT.
- Earliest next gnt is in cycle T+3+ADD_LAT, so throughput is one op per ADD_LAT+2 cycles.
- Outputs are all registered; there is no combinational path from req to gnt.

## Configuration
- Macro: ADD_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at pointer p and wraps modulo NREQ.
  - After each grant, p = winner+1 (mod NREQ).
  - p resets to 0.
- Undefined: fixed priority; the lowest asserted index wins. The pointer logic is absent.
- Both modes use identical port lists and timing.

## Structure
- Package add_arb_pkg:
  - state encoding constants IDLE/WAIT
  - helper functions deriving CW = W+2 and IDW = clog2(NREQ), with IDW forced to a minimum of 1
- Sub-module add_arb_pick: combinational picker.
  - Inputs: req and start pointer.
  - Outputs: found and winner index.
  - Fixed priority is the pointer-tied-to-0 case.

## Test plan
Bench settings: NREQ=4, W=1, ADD_LAT=1, ADD_ARB_RR_EN defined, `addr` instantiated as the adder; T is the grant sample edge in each scenario.
- Reset: rst=1 for 2 cycles with all req=1 -> every output is 0 and no gnt appears; first gnt = 4'b0001 in the cycle after rst deasserts.
- Single request: req=4'b0100, op_a[2]=1, op_b[2]=1 at T -> gnt=4'b0100 and add_a=add_b=1 at T+1; rsp_valid at T+3 with rsp_id=2, rsp_data=3'b010.
- Saturating load: req=4'b1111 held -> grant order 0,1,2,3,0, spaced 3 cycles apart. With the macro undefined the order is 0,0,0.
- Reset mid-operation: rst pulsed in the cycle after a gnt to requester 3 -> no rsp_valid; next grant goes to requester 0.
- Longer adder latency: ADD_LAT=3, single req to requester 1 with op_a=0, op_b=1 -> rsp_valid at T+5 with rsp_id=1, rsp_data=3'b001; busy is high from T+1 to T+4.
- Operand change after grant: requester 0 changes op_a from 1 to 0 in the gnt cycle -> the response reflects the captured operands (1+op_b).

Source files
------------

// File: rtl/add_arb_pkg.sv
// ----------------------------------------------------------------------------
// add_arb_pkg
// Shared definitions for the add_arbiter slice:
//   - arb_state_e : arbiter FSM state encoding (IDLE / WAIT)
//   - calc_cw     : adder result width from operand width (W + 2)
//   - calc_idw    : requester-index width, never narrower than 1 bit
// ----------------------------------------------------------------------------
package add_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  function automatic int calc_cw(input int w);
    return w + 2;
  endfunction

  // A 1-requester or 2-requester system still needs a 1-bit index.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_arb_if.sv
// ----------------------------------------------------------------------------
// add_arb_if
// Bundles the requester handshake and the shared-adder connection.
// Parameters: NREQ requesters, W operand bits per requester.
// Signals:
//   req, op_a, op_b      requester -> arbiter (operand i at [i*W +: W])
//   gnt                  arbiter -> requester, one-hot accept pulse
//   add_a, add_b         arbiter -> adder operands
//   add_c                adder -> arbiter result (CW bits)
//   rsp_valid/id/data    arbiter -> requesters, tagged result pulse
//   busy                 arbiter operation in flight
// Modports: slave (the arbiter), master (requesters plus adder side).
// ----------------------------------------------------------------------------
interface add_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 1
);
  import add_arb_pkg::*;

  localparam int CW  = calc_cw(W);
  localparam int IDW = calc_idw(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [CW-1:0]     add_c;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [CW-1:0]     rsp_data;
  logic              busy;

  modport slave (
    input  req, op_a, op_b, add_c,
    output gnt, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req, op_a, op_b, add_c,
    input  gnt, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/add_arb_pick.sv
// ----------------------------------------------------------------------------
// add_arb_pick
// Combinational request picker. Scans i_req starting at i_ptr and wrapping
// modulo NREQ; the first asserted bit wins. With i_ptr tied to 0 this is
// plain lowest-index-wins fixed priority.
// Ports:
//   i_req   [NREQ]  request vector
//   i_ptr   [IDW]   index where the scan starts (must be < NREQ)
//   o_found         at least one request is asserted
//   o_idx   [IDW]   index of the winning requester (0 when none)
// ----------------------------------------------------------------------------
module add_arb_pick
  import add_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_found,
  output logic [IDW-1:0]  o_idx
);

  // Requests rotated so that bit k corresponds to requester (i_ptr + k) mod NREQ.
  logic [NREQ-1:0] w_rot;

  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NREQ) ? (s - NREQ) : s;
  endfunction

  // First-set search over the rotated vector, mapped back to a real index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_found && w_rot[k]) begin
        o_found = 1'b1;
        o_idx   = IDW'(wrap_idx(int'(i_ptr), k));
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/addr.sv
// ----------------------------------------------------------------------------
// addr
// Registered adder shared through add_arbiter: c = a + b, LAT clocks after
// a/b are sampled. Pure datapath, no reset; the arbiter ignores its output
// unless an operation is in flight.
// Ports:
//   clk          clock
//   a, b  [W]    operands
//   c     [W+2]  sum
// ----------------------------------------------------------------------------
module addr #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W+1:0] c
);

  localparam int CW = W + 2;

  logic [CW-1:0] r_pipe [LAT];

  // Sum stage followed by LAT-1 delay stages.
  always_ff @(posedge clk) begin
    r_pipe[0] <= CW'(a) + CW'(b);
    for (int i = 1; i < LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign c = r_pipe[LAT-1];

endmodule

// File: rtl/add_arbiter.sv
// ----------------------------------------------------------------------------
// add_arbiter
// Shares one registered adder among NREQ requesters. A pending request is
// arbitrated in IDLE, its operands are captured and driven to the adder,
// the FSM waits ADD_LAT clocks in WAIT, then the adder result is returned
// with the owning requester index. One operation in flight at a time.
//
// Build option: define ADD_ARB_RR_EN for round-robin arbitration (search
// starts at a pointer that moves to winner+1 after each grant). Without it
// the lowest asserted index wins.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset, aborts any operation in flight
//   bus    add_arb_if.slave: req/op_a/op_b/add_c in;
//          gnt/add_a/add_b/rsp_valid/rsp_id/rsp_data/busy out (all registered)
// Parameters: NREQ requesters, W operand width, ADD_LAT adder latency (>= 1).
// ----------------------------------------------------------------------------
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 1,
  parameter int ADD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  add_arb_if.slave bus
);

  localparam int CW   = calc_cw(W);
  localparam int IDW  = calc_idw(NREQ);
  localparam int CNTW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  arb_state_e      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [W-1:0]    r_add_a;
  logic [W-1:0]    r_add_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [CW-1:0]   r_rsp_data;
  logic            r_busy;
  logic [IDW-1:0]  r_win;
  logic [CNTW-1:0] r_cnt;

  logic [IDW-1:0]  w_ptr;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [W-1:0]    w_op_a;
  logic [W-1:0]    w_op_b;

`ifdef ADD_ARB_RR_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;

  // Pointer moves just past the winner, wrapping at NREQ.
  always_comb begin
    w_ptr_nxt = '0;
    if (w_win == IDW'(NREQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + IDW'(1);
    end
  end

  // Round-robin pointer, advanced only when a grant is issued from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if ((r_state == IDLE) && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  add_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // Select the winner's operand slices.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_op_a = bus.op_a[i*W +: W];
        w_op_b = bus.op_b[i*W +: W];
      end else begin
        w_op_a = w_op_a;
        w_op_b = w_op_b;
      end
    end
  end

  // Arbiter FSM: grant and capture in IDLE, count adder latency in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_win       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          r_cnt       <= '0;
          if (w_found) begin
            r_gnt   <= GNT_ONE << w_win;
            r_add_a <= w_op_a;
            r_add_b <= w_op_b;
            r_win   <= w_win;
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end else begin
            r_gnt   <= '0;
          end
        end
        WAIT: begin
          // Requests are ignored here, including the winner still holding req.
          r_gnt <= '0;
          if (r_cnt == CNTW'(ADD_LAT)) begin
            r_rsp_data  <= bus.add_c;
            r_rsp_id    <= r_win;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end else begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= r_cnt + CNTW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= '0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_add_arbiter
// Self-checking bench for add_arbiter. DUT1: NREQ=4, W=1, ADD_LAT=1 with a
// 1-cycle addr. DUT3: same but ADD_LAT=3 with a 3-cycle addr. Expected
// responses of DUT1 go into a scoreboard queue when a grant is observed and
// are popped by a monitor when rsp_valid pulses. Arbitration order follows
// ADD_ARB_RR_EN as compiled.
// ----------------------------------------------------------------------------
module tb_add_arbiter;
  import add_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 1;
  localparam int L1   = 1;
  localparam int L3   = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  add_arb_if #(.NREQ(NREQ), .W(W)) bus1 ();
  add_arb_if #(.NREQ(NREQ), .W(W)) bus3 ();

  add_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(L1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  addr #(.W(W), .LAT(L1)) u_add1 (
    .clk (clk),
    .a   (bus1.add_a),
    .b   (bus1.add_b),
    .c   (bus1.add_c)
  );

  add_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(L3)) u_dut3 (
    .clk (clk),
    .rst (rst2),
    .bus (bus3)
  );

  addr #(.W(W), .LAT(L3)) u_add3 (
    .clk (clk),
    .a   (bus3.add_a),
    .b   (bus3.add_b),
    .c   (bus3.add_c)
  );

  typedef struct {
    int id;
    int data;
    int cyc;
  } rsp_t;

  typedef struct {
    logic [3:0] req;
    logic       a;
    logic       b;
    logic [3:0] exp_gnt;
    int         exp_id;
    logic [2:0] exp_data;
  } vec_t;

  rsp_t sbq[$];
  rsp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Edge counter used to time grants and responses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Response monitor for DUT1: pops the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (bus1.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'(bus1.rsp_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(bus1.rsp_id), mon_e.id);
        chk("rsp_data", 32'(bus1.rsp_data), mon_e.data);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 12) begin
      tick();
      n++;
    end
    chk(tag, 32'(sbq.size()), 32'd0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(bus1.gnt), 32'd0);
    chk({tag, "_add_a"}, 32'(bus1.add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(bus1.add_b), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus1.rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus1.rsp_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_busy3"}, 32'(bus3.busy), 32'd0);
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [5];
    int         exp_order [5];
    logic [3:0] sat_a;
    logic [3:0] sat_b;
    logic [3:0] va;
    logic [3:0] vb;
    int         ng;
    int         last_g;
    int         first_g;
    int         rel_cyc;
    int         mid_ids [2];
    logic [3:0] onehot;

    vt[0] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 0, 3'b001};
    vt[1] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1, 3'b010};
    vt[2] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2, 3'b010};
    vt[3] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 3, 3'b000};
    vt[4] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 3, 3'b001};
`ifdef ADD_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    mid_ids = '{3, 1};
    sat_a   = 4'b1010;
    sat_b   = 4'b0110;

    bus3.req  = 4'b0000;
    bus3.op_a = 4'b0000;
    bus3.op_b = 4'b0000;

    // Reset with every requester asserting.
    bus1.req  = 4'b1111;
    bus1.op_a = sat_a;
    bus1.op_b = sat_b;
    rst  = 1'b1;
    rst2 = 1'b1;
    tick();
    chk_reset_outputs("reset_c1");
    tick();
    chk_reset_outputs("reset_c2");
    rst     = 1'b0;
    rst2    = 1'b0;
    rel_cyc = cyc;

    // Saturating load: req held at 4'b1111.
    ng      = 0;
    last_g  = -1;
    first_g = -1;
    for (int t = 0; t < 20 && ng < 5; t++) begin
      tick();
      if (bus1.gnt !== 4'b0000) begin
        if (ng == 0) first_g = cyc;
        chk("sat_gnt", 32'(bus1.gnt), 32'd1 << exp_order[ng]);
        chk("sat_add_a", 32'(bus1.add_a), 32'(sat_a[exp_order[ng]]));
        chk("sat_add_b", 32'(bus1.add_b), 32'(sat_b[exp_order[ng]]));
        chk("sat_busy", 32'(bus1.busy), 32'd1);
        if (ng > 0) chk("sat_spacing", cyc - last_g, 3);
        sbq.push_back('{exp_order[ng], 32'(sat_a[exp_order[ng]]) + 32'(sat_b[exp_order[ng]]), cyc + L1 + 1});
        last_g = cyc;
        ng++;
        if (ng == 5) bus1.req = 4'b0000;
      end
    end
    chk("sat_grant_count", ng, 5);
    chk("reset_first_gnt_cycle", first_g, rel_cyc + 1);
    drain("sat_drain");

    // Table of single-request transactions.
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < NREQ; s++) begin
        va[s] = vt[i].req[s] ? vt[i].a : ~vt[i].a;
        vb[s] = vt[i].req[s] ? vt[i].b : ~vt[i].b;
      end
      bus1.op_a = va;
      bus1.op_b = vb;
      bus1.req  = vt[i].req;
      tick();
      chk("vec_gnt", 32'(bus1.gnt), 32'(vt[i].exp_gnt));
      chk("vec_add_a", 32'(bus1.add_a), 32'(vt[i].a));
      chk("vec_add_b", 32'(bus1.add_b), 32'(vt[i].b));
      chk("vec_busy", 32'(bus1.busy), 32'd1);
      sbq.push_back('{vt[i].exp_id, 32'(vt[i].exp_data), cyc + L1 + 1});
      bus1.req  = 4'b0000;
      bus1.op_a = ~va;
      bus1.op_b = ~vb;
      drain("vec_drain");
      chk("vec_hold_valid", 32'(bus1.rsp_valid), 32'd0);
      chk("vec_hold_id", 32'(bus1.rsp_id), vt[i].exp_id);
      chk("vec_hold_data", 32'(bus1.rsp_data), 32'(vt[i].exp_data));
      chk("vec_hold_add_a", 32'(bus1.add_a), 32'(vt[i].a));
      chk("vec_idle_busy", 32'(bus1.busy), 32'd0);
    end

    // Operand change during the grant cycle must not affect the result.
    bus1.op_a = 4'b0001;
    bus1.op_b = 4'b0001;
    bus1.req  = 4'b0001;
    tick();
    chk("opchg_gnt", 32'(bus1.gnt), 32'd1);
    bus1.op_a = 4'b0000;
    bus1.req  = 4'b0000;
    sbq.push_back('{0, 2, cyc + L1 + 1});
    drain("opchg_drain");

    // Reset pulsed right after a grant: result discarded, pointer back to 0.
    for (int m = 0; m < 2; m++) begin
      onehot    = 4'b0001 << mid_ids[m];
      bus1.op_a = 4'b1111;
      bus1.op_b = 4'b1111;
      bus1.req  = onehot;
      tick();
      chk("mid_gnt", 32'(bus1.gnt), 32'(onehot));
      bus1.req = 4'b0000;
      rst      = 1'b1;
      tick();
      chk("mid_rst_busy", 32'(bus1.busy), 32'd0);
      chk("mid_rst_gnt", 32'(bus1.gnt), 32'd0);
      chk("mid_rst_valid", 32'(bus1.rsp_valid), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("mid_no_rsp", 32'(bus1.rsp_valid), 32'd0);
      end
      bus1.op_a = 4'b0101;
      bus1.op_b = 4'b0001;
      bus1.req  = 4'b1111;
      tick();
      chk("mid_next_gnt", 32'(bus1.gnt), 32'd1);
      sbq.push_back('{0, 2, cyc + L1 + 1});
      bus1.req = 4'b0000;
      drain("mid_drain");
    end

    // ADD_LAT=3 instance: single request from requester 1, 0+1.
    bus3.op_a = 4'b1101;
    bus3.op_b = 4'b0010;
    bus3.req  = 4'b0010;
    tick();
    chk("lat3_gnt", 32'(bus3.gnt), 32'b0010);
    chk("lat3_busy_t1", 32'(bus3.busy), 32'd1);
    bus3.req = 4'b0000;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("lat3_busy_mid", 32'(bus3.busy), 32'd1);
      chk("lat3_no_rsp_yet", 32'(bus3.rsp_valid), 32'd0);
    end
    tick();
    chk("lat3_rsp_valid", 32'(bus3.rsp_valid), 32'd1);
    chk("lat3_rsp_id", 32'(bus3.rsp_id), 32'd1);
    chk("lat3_rsp_data", 32'(bus3.rsp_data), 32'd1);
    chk("lat3_busy_done", 32'(bus3.busy), 32'd0);
    tick();
    chk("lat3_rsp_pulse", 32'(bus3.rsp_valid), 32'd0);

    tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
